// File: rtl/formula_isqrt_sum_n_fsm.sv
// Sums isqrt(arg[i]) over N_ARGS arguments by time-sharing N_ISQRT external isqrt units in batches.
// Optional per-batch watchdog enabled by defining ISQRT_TIMEOUT_EN.
module formula_isqrt_sum_n_fsm #(
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arg_vld,
    output logic                       arg_rdy,
    input  logic [N_ARGS*W-1:0]        args,
    output logic                       res_vld,
    output logic [W-1:0]               res,
    output logic                       res_err,
    output logic [N_ISQRT-1:0]         isqrt_x_vld,
    output logic [N_ISQRT*W-1:0]       isqrt_x,
    input  logic [N_ISQRT-1:0]         isqrt_y_vld,
    input  logic [N_ISQRT*(W/2)-1:0]   isqrt_y
);

    localparam int HW = W / 2;
    localparam int NB = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [N_ARGS*W-1:0]  args_q;
    logic [W-1:0]         acc;
    logic [W-1:0]         lane_sum;
    logic [BW-1:0]        batch;
    logic [N_ISQRT-1:0]   done;
    logic [N_ISQRT-1:0]   lane_act;
    logic [N_ISQRT-1:0]   hits;
    logic                 batch_done;
    logic                 last_batch;
    logic                 timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A lane is active in this batch only if it maps to a real argument index.
    always_comb begin
        lane_act = '0;
        for (int k = 0; k < N_ISQRT; k++)
            if (int'(batch) * N_ISQRT + k < N_ARGS)
                lane_act[k] = 1'b1;
    end

    assign hits       = isqrt_y_vld & lane_act & ~done & {N_ISQRT{state == WAIT}};
    assign batch_done = ((done | hits) & lane_act) == lane_act;
    assign last_batch = (batch == BW'(NB - 1));

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < N_ISQRT; k++)
            if (hits[k])
                lane_sum = lane_sum + W'(isqrt_y[k*HW +: HW]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arg_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (batch_done)
                    state_nxt = last_batch ? IDLE : ISSUE;
                else if (timeout_hit)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        arg_rdy     = (state == IDLE);
        isqrt_x_vld = '0;
        isqrt_x     = '0;
        for (int k = 0; k < N_ISQRT; k++)
            for (int i = 0; i < N_ARGS; i++)
                if (state == ISSUE && int'(batch) * N_ISQRT + k == i) begin
                    isqrt_x_vld[k]      = 1'b1;
                    isqrt_x[k*W +: W]   = args_q[i*W +: W];
                end
    end

    // Accumulates completed lanes; the final batch also publishes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            args_q  <= '0;
            acc     <= '0;
            batch   <= '0;
            done    <= '0;
            res     <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (arg_vld) begin
                        args_q <= args;
                        acc    <= '0;
                        batch  <= '0;
                    end
                end
                ISSUE: done <= '0;
                WAIT: begin
                    acc  <= acc + lane_sum;
                    done <= done | hits;
                    if (batch_done) begin
                        if (last_batch) begin
                            res     <= acc + lane_sum;
                            res_vld <= 1'b1;
                        end else begin
                            batch <= batch + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ISQRT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

    // Counter is zero in the first WAIT cycle, so the abort fires after TIMEOUT WAIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            res_err  <= 1'b0;
        end else begin
            res_err <= 1'b0;
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == WAIT && !batch_done && timeout_hit)
                res_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_formula_isqrt_sum_n_fsm.sv
// Directed self-checking bench for formula_isqrt_sum_n_fsm with a per-lane isqrt unit model.
// Also exercises the watchdog when ISQRT_TIMEOUT_EN is defined.
module tb_formula_isqrt_sum_n_fsm;

    logic          clk = 1'b0;
    logic          rst;
    logic          arg_vld;
    logic          arg_rdy;
    logic [95:0]   args;
    logic          res_vld;
    logic [31:0]   res;
    logic          res_err;
    logic [1:0]    isqrt_x_vld;
    logic [63:0]   isqrt_x;
    logic [1:0]    isqrt_y_vld = '0;
    logic [31:0]   isqrt_y = '0;

    int total = 0;
    int bad = 0;
    int accepts = 0;
    int lat[2]   = '{1, 1};
    int hold[2]  = '{1, 1};
    int mcnt[2]  = '{0, 0};
    int mhold[2] = '{0, 0};
    logic [15:0] mroot[2] = '{16'd0, 16'd0};

    formula_isqrt_sum_n_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .arg_vld     (arg_vld),
        .arg_rdy     (arg_rdy),
        .args        (args),
        .res_vld     (res_vld),
        .res         (res),
        .res_err     (res_err),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] isqrt32(input logic [31:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, v})
                r = t;
        end
        return r[15:0];
    endfunction

    // Isqrt unit model: lat cycles to respond (0 = never), strobe held for hold cycles.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mhold[k] > 0) begin
                mhold[k]--;
                if (mhold[k] == 0) isqrt_y_vld[k] = 1'b0;
            end
            if (mcnt[k] > 0) begin
                mcnt[k]--;
                if (mcnt[k] == 0) begin
                    isqrt_y_vld[k]      = 1'b1;
                    isqrt_y[k*16 +: 16] = mroot[k];
                    mhold[k]            = hold[k];
                end
            end
            if (isqrt_x_vld[k] && lat[k] > 0) begin
                mcnt[k]  = lat[k];
                mroot[k] = isqrt32(isqrt_x[k*32 +: 32]);
            end
        end
    end

    always @(posedge clk)
        if (!rst && arg_vld && arg_rdy) accepts++;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Presents one argument vector; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input bit keep);
        @(negedge clk);
        args    = {a2, a1, a0};
        arg_vld = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) arg_vld = 1'b0;
    endtask

    task automatic waitResult(output int n, output int iss, output logic [31:0] r);
        bit got;
        n   = 0;
        iss = -1;
        got = 0;
        while (!got && n < 200) begin
            if (n > 0 && isqrt_x_vld != 2'b00 && iss < 0) iss = n;
            if (res_vld) got = 1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!got) checkOutput("res_vld_timeout", 64'(n), 64'd0);
        r = res;
    endtask

    initial begin
        int n, iss, a0;
        logic [31:0] r;
        bit seen;

        #200000;
        $display("[TB] FAIL global_watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int n, iss, a0;
        logic [31:0] r;
        bit seen, saw_err, saw_vld;

        rst     = 1'b1;
        arg_vld = 1'b0;
        args    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_arg_rdy", 64'(arg_rdy), 64'd1);
        checkOutput("rst_res_vld", 64'(res_vld), 64'd0);
        checkOutput("rst_res", 64'(res), 64'd0);
        checkOutput("rst_res_err", 64'(res_err), 64'd0);
        checkOutput("rst_x_vld", 64'(isqrt_x_vld), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] cycle-by-cycle {16,25,36}");
        applyStimulus(32'd16, 32'd25, 32'd36, 1'b0);
        checkOutput("b0_x_vld", 64'(isqrt_x_vld), 64'd3);
        checkOutput("b0_x0", 64'(isqrt_x[31:0]), 64'd16);
        checkOutput("b0_x1", 64'(isqrt_x[63:32]), 64'd25);
        checkOutput("busy_arg_rdy", 64'(arg_rdy), 64'd0);
        @(posedge clk); #1;
        checkOutput("wait0_x_vld", 64'(isqrt_x_vld), 64'd0);
        @(posedge clk); #1;
        checkOutput("b1_x_vld", 64'(isqrt_x_vld), 64'd1);
        checkOutput("b1_x0", 64'(isqrt_x[31:0]), 64'd36);
        checkOutput("b1_x1", 64'(isqrt_x[63:32]), 64'd0);
        @(posedge clk); #1;
        checkOutput("wait1_res_vld", 64'(res_vld), 64'd0);
        @(posedge clk); #1;
        checkOutput("t5_res_vld", 64'(res_vld), 64'd1);
        checkOutput("t5_res", 64'(res), 64'd15);
        checkOutput("t5_arg_rdy", 64'(arg_rdy), 64'd1);
        @(posedge clk); #1;
        checkOutput("pulse_res_vld", 64'(res_vld), 64'd0);
        checkOutput("held_res", 64'(res), 64'd15);

        $display("[TB] back-to-back and held arg_vld");
        a0 = accepts;
        applyStimulus(32'd4, 32'd9, 32'd16, 1'b0);
        waitResult(n, iss, r);
        checkOutput("b2b_a_res", 64'(r), 64'd9);
        checkOutput("b2b_a_lat", 64'(n), 64'd4);
        checkOutput("b2b_a_iss", 64'(iss), 64'd2);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checkOutput("b2b_b_taken", 64'(arg_rdy), 64'd0);
        waitResult(n, iss, r);
        arg_vld = 1'b0;
        checkOutput("max_res", 64'(r), 64'd196605);
        checkOutput("max_lat", 64'(n), 64'd4);
        checkOutput("accept_count", 64'(accepts - a0), 64'd2);

        applyStimulus(32'd0, 32'd0, 32'd0, 1'b0);
        waitResult(n, iss, r);
        checkOutput("zero_res", 64'(r), 64'd0);

        $display("[TB] lane skew with duplicate strobes");
        lat  = '{1, 4};
        hold = '{2, 2};
        applyStimulus(32'd4, 32'd9, 32'd1, 1'b0);
        waitResult(n, iss, r);
        checkOutput("skew_res", 64'(r), 64'd6);
        checkOutput("skew_lat", 64'(n), 64'd7);
        checkOutput("skew_iss", 64'(iss), 64'd5);

        $display("[TB] reset during WAIT");
        hold = '{1, 1};
        repeat (4) @(posedge clk);
        applyStimulus(32'd4, 32'd9, 32'd1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_res", 64'(res), 64'd0);
        checkOutput("arst_res_vld", 64'(res_vld), 64'd0);
        checkOutput("arst_arg_rdy", 64'(arg_rdy), 64'd1);
        checkOutput("arst_x_vld", 64'(isqrt_x_vld), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_vld || arg_rdy !== 1'b1) seen = 1;
        end
        checkOutput("late_y_ignored", 64'(seen), 64'd0);
        lat = '{1, 1};
        applyStimulus(32'd1, 32'd1, 32'd1, 1'b0);
        waitResult(n, iss, r);
        checkOutput("post_rst_res", 64'(r), 64'd3);
        checkOutput("post_rst_lat", 64'(n), 64'd4);

`ifdef ISQRT_TIMEOUT_EN
        $display("[TB] watchdog with silent lane 1");
        lat = '{1, 0};
        applyStimulus(32'd4, 32'd9, 32'd1, 1'b0);
        n       = 0;
        saw_err = 0;
        saw_vld = 0;
        while (!saw_err && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (res_vld) saw_vld = 1;
            if (res_err) saw_err = 1;
        end
        checkOutput("to_err_seen", 64'(saw_err), 64'd1);
        checkOutput("to_err_cycle", 64'(n), 64'd65);
        checkOutput("to_no_res_vld", 64'(saw_vld), 64'd0);
        checkOutput("to_res_kept", 64'(res), 64'd3);
        checkOutput("to_arg_rdy", 64'(arg_rdy), 64'd1);
        @(posedge clk); #1;
        checkOutput("to_err_pulse", 64'(res_err), 64'd0);
`else
        checkOutput("res_err_tied", 64'(res_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
